// File: rtl/sdram_ctl.sv
// SDRAM responder for the REU DMA sequencer: one access slot and one auto-refresh slot per PHI2
// cycle against a x8 SDR SDRAM, after the power-up init sequence.
module sdram_ctl #(
    parameter int INIT_WAIT = 5000,
    parameter int T_RCD     = 2,
    parameter int CL        = 2,
    parameter int T_RC      = 8,
    parameter int SLOT_REF  = 12
) (
    input  logic        C25M,
    input  logic        nRESET,
    input  logic        PHI2,
    input  logic        RAMRD,
    input  logic        RAMWR,
    input  logic [23:0] RA,
    input  logic [7:0]  Din,
    output logic [7:0]  Dout,
    output logic        Ready,
    output logic        CKE,
    output logic        nCS,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nWE,
    output logic [1:0]  BA,
    output logic [11:0] SA,
    output logic        DQM,
    output logic [7:0]  DQout,
    output logic        DQoe,
    input  logic [7:0]  DQin
);
    localparam int CW = $clog2(INIT_WAIT + SLOT_REF + T_RC + 1);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(INIT_WAIT);
    localparam logic [CW-1:0] CNT_TRC  = CW'(T_RC);
    localparam logic [CW-1:0] CNT_MRD  = CW'(2);
    localparam logic [CW-1:0] CNT_TRCD = CW'(T_RCD);
    localparam logic [CW-1:0] CNT_DOUT = CW'(T_RCD + CL + 2);
    localparam logic [CW-1:0] CNT_REF  = CW'(SLOT_REF - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(SLOT_REF + T_RC - 2);

    // Burst length 1, sequential, single-location writes
    localparam logic [11:0] MODE_WORD = {5'b00000, 3'(CL), 4'b0000};

    localparam logic [3:0] CMD_RST = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PC  = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    typedef enum logic [2:0] {
        S_WAIT, S_PRE, S_REF1, S_REF2, S_MRS, S_IDLE, S_SLOT
    } state_t;

    state_t       state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]   phiSync;
    logic [3:0]   cmdReg, cmdNext;
    logic [1:0]   baReg, baNext;
    logic [11:0]  saReg, saNext;
    logic         dqmReg, dqmNext, dqoeReg, dqoeNext, readyReg, readyNext, ckeReg;
    logic [7:0]   dqoutReg, dqoutNext, doutReg, doutNext, dinReg, dinNext, dqInReg;
    logic         pendRd, pendRdNext, pendWr, pendWrNext;
    logic [9:0]   colReg, colNext;
    logic         phiFall;

    assign phiFall = !phiSync[1] && phiSync[2];

    always_ff @(posedge C25M or negedge nRESET) begin
        if (!nRESET) begin
            state    <= S_WAIT;
            cnt      <= '0;
            phiSync  <= '0;
            cmdReg   <= CMD_RST;
            baReg    <= '0;
            saReg    <= '0;
            dqmReg   <= 1'b1;
            dqoeReg  <= 1'b0;
            dqoutReg <= '0;
            doutReg  <= '0;
            readyReg <= 1'b0;
            ckeReg   <= 1'b0;
            pendRd   <= 1'b0;
            pendWr   <= 1'b0;
            colReg   <= '0;
            dinReg   <= '0;
            dqInReg  <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            phiSync  <= {phiSync[1:0], PHI2};
            cmdReg   <= cmdNext;
            baReg    <= baNext;
            saReg    <= saNext;
            dqmReg   <= dqmNext;
            dqoeReg  <= dqoeNext;
            dqoutReg <= dqoutNext;
            doutReg  <= doutNext;
            readyReg <= readyNext;
            ckeReg   <= 1'b1;
            pendRd   <= pendRdNext;
            pendWr   <= pendWrNext;
            colReg   <= colNext;
            dinReg   <= dinNext;
            dqInReg  <= DQin;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        cmdNext    = CMD_NOP;
        baNext     = baReg;
        saNext     = saReg;
        dqmNext    = 1'b1;
        dqoeNext   = 1'b0;
        dqoutNext  = dqoutReg;
        doutNext   = doutReg;
        readyNext  = readyReg;
        pendRdNext = pendRd;
        pendWrNext = pendWr;
        colNext    = colReg;
        dinNext    = dinReg;
        case (state)
            S_WAIT: if (cnt == CNT_INIT) begin
                cmdNext = CMD_PC; saNext = 12'h400; cntNext = CNT_ONE; stateNext = S_PRE;
            end
            S_PRE: if (cnt == CNT_TRC) begin
                cmdNext = CMD_REF; cntNext = CNT_ONE; stateNext = S_REF1;
            end
            S_REF1: if (cnt == CNT_TRC) begin
                cmdNext = CMD_REF; cntNext = CNT_ONE; stateNext = S_REF2;
            end
            S_REF2: if (cnt == CNT_TRC) begin
                cmdNext = CMD_MRS; baNext = 2'b00; saNext = MODE_WORD;
                cntNext = CNT_ONE; stateNext = S_MRS;
            end
            S_MRS: if (cnt == CNT_MRD) begin
                readyNext = 1'b1; stateNext = S_IDLE;
            end
            S_IDLE: if (phiFall) begin
                // cnt counts cycles since the detected fall, so cnt==k in cycle F+k
                cntNext    = CNT_ONE;
                stateNext  = S_SLOT;
                pendRdNext = RAMRD;
                pendWrNext = RAMWR && !RAMRD;
                colNext    = RA[9:0];
                dinNext    = Din;
                if (RAMRD || RAMWR) begin
                    cmdNext = CMD_ACT; baNext = RA[23:22]; saNext = RA[21:10];
                end
            end
            S_SLOT: begin
                if (cnt == CNT_TRCD && (pendRd || pendWr)) begin
                    cmdNext    = pendRd ? CMD_RD : CMD_WR;
                    saNext     = {1'b0, 1'b1, colReg};
                    dqmNext    = 1'b0;
                    dqoeNext   = pendWr;
                    dqoutNext  = pendWr ? dinReg : dqoutReg;
                    pendWrNext = 1'b0;
                end
                // Read data lands CL cycles after RD, then passes the input register
                if (pendRd && cnt == CNT_DOUT) begin
                    doutNext   = dqInReg;
                    pendRdNext = 1'b0;
                end
                if (cnt == CNT_REF) cmdNext = CMD_REF;
                if (cnt == CNT_END) stateNext = S_IDLE;
            end
            default: stateNext = S_WAIT;
        endcase
    end

    assign {nCS, nRAS, nCAS, nWE} = cmdReg;
    assign BA    = baReg;
    assign SA    = saReg;
    assign DQM   = dqmReg;
    assign DQoe  = dqoeReg;
    assign DQout = dqoutReg;
    assign Dout  = doutReg;
    assign Ready = readyReg;
    assign CKE   = ckeReg;
endmodule

// File: tb/tb_sdram_ctl.sv
// Bench for sdram_ctl: randomized PHI2-cycle requests checked against a request-level model and
// an SDRAM pin model that logs every command.
module tb_sdram_ctl;
    localparam int INIT_WAIT = 5000;
    localparam int T_RCD     = 2;
    localparam int CL        = 2;
    localparam int T_RC      = 8;
    localparam int SLOT_REF  = 12;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PC  = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        nRESET, PHI2, RAMRD, RAMWR;
    logic [23:0] RA;
    logic [7:0]  Din, Dout, DQout, DQin;
    logic        Ready, CKE, nCS, nRAS, nCAS, nWE, DQM, DQoe;
    logic [1:0]  BA;
    logic [11:0] SA;

    sdram_ctl #(
        .INIT_WAIT(INIT_WAIT), .T_RCD(T_RCD), .CL(CL), .T_RC(T_RC), .SLOT_REF(SLOT_REF)
    ) dut (
        .C25M(clk), .nRESET(nRESET), .PHI2(PHI2), .RAMRD(RAMRD), .RAMWR(RAMWR), .RA(RA),
        .Din(Din), .Dout(Dout), .Ready(Ready), .CKE(CKE), .nCS(nCS), .nRAS(nRAS),
        .nCAS(nCAS), .nWE(nWE), .BA(BA), .SA(SA), .DQM(DQM), .DQout(DQout), .DQoe(DQoe),
        .DQin(DQin)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [13:0] key;
        logic [9:0]  misc;
    } ev_t;

    ev_t  evQ[$];
    ev_t  expQ[$];
    int   cyc = 0;
    int   nCmp = 0;
    int   nErr = 0;
    int   refCnt = 0;
    int   actCnt = 0;
    int   rdDue = -1;
    logic [7:0]  rdData;
    logic [7:0]  lastRead = 8'h00;
    logic [11:0] openRow [4];
    logic [7:0]  sdMem  [logic [23:0]];
    logic [7:0]  refMem [logic [23:0]];
    logic [23:0] pool [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // Fields of a command that matter for checking; unspecified address bits are masked
    function automatic logic [13:0] keyOf(input logic [3:0] c, input logic [1:0] ba,
                                          input logic [11:0] sa);
        case (c)
            CMD_ACT:        return {ba, sa};
            CMD_RD, CMD_WR: return {ba, 1'b0, sa[10:0]};
            CMD_PC:         return {3'b000, sa[10], 10'd0};
            CMD_MRS:        return {2'b00, sa};
            default:        return 14'd0;
        endcase
    endfunction

    function automatic logic [7:0] memGet(input logic [23:0] a, input bit useRef);
        if (useRef) return refMem.exists(a) ? refMem[a] : 8'h00;
        return sdMem.exists(a) ? sdMem[a] : 8'h00;
    endfunction

    initial forever @(posedge clk) cyc++;

    // SDRAM pin model and command log
    initial begin
        logic [3:0] c;
        ev_t e;
        forever begin
            @(negedge clk);
            DQin = (cyc == rdDue) ? rdData : 8'($urandom);
            c = {nCS, nRAS, nCAS, nWE};
            if (!nCS && c == CMD_ACT) begin openRow[BA] = SA; actCnt++; end
            if (!nCS && c == CMD_REF) refCnt++;
            if (!nCS && c == CMD_RD) begin
                rdData = memGet({BA, openRow[BA], SA[9:0]}, 1'b0);
                rdDue  = cyc + CL;
            end
            if (!nCS && c == CMD_WR && DQoe) sdMem[{BA, openRow[BA], SA[9:0]}] = DQout;
            if ((!nCS && c != CMD_NOP) || !DQM || DQoe) begin
                e.cyc  = cyc;
                e.cmd  = c;
                e.key  = keyOf(c, BA, SA);
                e.misc = {DQM, DQoe, DQoe ? DQout : 8'h00};
                evQ.push_back(e);
            end
        end
    end

    task automatic addExp(input int c, input logic [3:0] cmd, input logic [13:0] key,
                          input logic [9:0] misc);
        ev_t e;
        e.cyc = c; e.cmd = cmd; e.key = key; e.misc = misc;
        expQ.push_back(e);
    endtask

    task automatic compareLog(input string tag);
        chk({tag, "_count"}, 32'(evQ.size()), 32'(expQ.size()));
        for (int i = 0; i < evQ.size() && i < expQ.size(); i++) begin
            chk({tag, "_cyc"},  32'(evQ[i].cyc),  32'(expQ[i].cyc));
            chk({tag, "_cmd"},  32'(evQ[i].cmd),  32'(expQ[i].cmd));
            chk({tag, "_addr"}, 32'(evQ[i].key),  32'(expQ[i].key));
            chk({tag, "_dq"},   32'(evQ[i].misc), 32'(expQ[i].misc));
        end
        evQ.delete();
        expQ.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_ctl"}, 32'({CKE, nCS, nRAS, nCAS, nWE, DQM, DQoe, Ready}), 32'b0_1111_1_0_0);
        chk({tag, "_addr"}, 32'({BA, SA}), 32'h0);
        chk({tag, "_data"}, 32'({DQout, Dout}), 32'h0);
    endtask

    task automatic releaseInit(input bit withReq);
        int c0, pc;
        repeat (3) @(negedge clk);
        evQ.delete();
        nRESET = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("cke_on", 32'(CKE), 32'd1);
        if (withReq) begin
            RAMWR = 1'b1; RA = 24'($urandom); Din = 8'($urandom); PHI2 = 1'b0;
            repeat (13) @(negedge clk);
            PHI2 = 1'b1; RAMWR = 1'b0;
        end
        pc = c0 + INIT_WAIT + 1;
        while (cyc < pc + 3 * T_RC + 1) @(negedge clk);
        chk("ready_early", 32'(Ready), 32'd0);
        @(negedge clk);
        chk("ready", 32'(Ready), 32'd1);
        addExp(pc,            CMD_PC,  {3'b000, 1'b1, 10'd0}, 10'h200);
        addExp(pc + T_RC,     CMD_REF, 14'd0,                 10'h200);
        addExp(pc + 2 * T_RC, CMD_REF, 14'd0,                 10'h200);
        addExp(pc + 3 * T_RC, CMD_MRS, {2'b00, 12'h020},      10'h200);
        compareLog("init");
        lastRead = 8'h00;
        $display("init  release=%0d precharge=%0d withReq=%0b", c0, pc, withReq);
    endtask

    task automatic phiCycle(input bit rd, input bit wr, input logic [23:0] ra,
                            input logic [7:0] din);
        int f;
        logic [7:0] exp;
        exp = rd ? memGet(ra, 1'b1) : lastRead;
        @(negedge clk);
        RAMRD = rd; RAMWR = wr; RA = ra; Din = din; PHI2 = 1'b0;
        f = cyc + 2;
        for (int k = 1; k < 25; k++) begin
            @(negedge clk);
            if (k == 13) begin PHI2 = 1'b1; RAMRD = 1'b0; RAMWR = 1'b0; end
            if (rd && cyc == f + 6) chk("dout_early", 32'(Dout), 32'(lastRead));
            if (rd && cyc == f + 7) chk("dout_lat", 32'(Dout), 32'(exp));
        end
        if (rd || wr) begin
            addExp(f + 1, CMD_ACT, {ra[23:22], ra[21:10]}, 10'h200);
            if (rd) addExp(f + 1 + T_RCD, CMD_RD, {ra[23:22], 1'b0, 1'b1, ra[9:0]}, 10'h000);
            else    addExp(f + 1 + T_RCD, CMD_WR, {ra[23:22], 1'b0, 1'b1, ra[9:0]}, {2'b01, din});
        end
        addExp(f + SLOT_REF, CMD_REF, 14'd0, 10'h200);
        compareLog("slot");
        if (rd) lastRead = exp;
        else if (wr) refMem[ra] = din;
        chk("dout_hold", 32'(Dout), 32'(lastRead));
        $display("phi   fall=%0d rd=%0b wr=%0b ra=%h din=%h dout=%h", f, rd, wr, ra, din, Dout);
    endtask

    task automatic phiFast(input logic [23:0] ra, input logic [7:0] din);
        int f;
        @(negedge clk);
        RAMWR = 1'b1; RA = ra; Din = din; PHI2 = 1'b0;
        f = cyc + 2;
        for (int k = 1; k < 25; k++) begin
            @(negedge clk);
            if (k == 4) PHI2 = 1'b1;
            if (k == 8) PHI2 = 1'b0;
            if (k == 14) begin PHI2 = 1'b1; RAMWR = 1'b0; end
        end
        addExp(f + 1, CMD_ACT, {ra[23:22], ra[21:10]}, 10'h200);
        addExp(f + 1 + T_RCD, CMD_WR, {ra[23:22], 1'b0, 1'b1, ra[9:0]}, {2'b01, din});
        addExp(f + SLOT_REF, CMD_REF, 14'd0, 10'h200);
        compareLog("fast");
        refMem[ra] = din;
        $display("fast  fall=%0d ra=%h din=%h", f, ra, din);
    endtask

    task automatic midReset(input logic [23:0] ra);
        int f;
        @(negedge clk);
        RAMWR = 1'b1; RA = ra; Din = 8'hC3; PHI2 = 1'b0;
        f = cyc + 2;
        while (cyc < f + 2) @(negedge clk);
        nRESET = 1'b0;
        #1;
        checkResetOutputs("midrst");
        addExp(f + 1, CMD_ACT, {ra[23:22], ra[21:10]}, 10'h200);
        compareLog("midrst");
        repeat (3) @(negedge clk);
        PHI2 = 1'b1; RAMWR = 1'b0;
        $display("reset asserted mid-access fall=%0d ra=%h", f, ra);
        releaseInit(1'b1);
    endtask

    initial begin
        int refBase, actBase, op;
        logic [23:0] a;
        nRESET = 1'b0; PHI2 = 1'b1; RAMRD = 1'b0; RAMWR = 1'b0;
        RA = '0; Din = '0; DQin = '0;
        for (int i = 0; i < 4; i++) openRow[i] = '0;
        pool[0] = 24'hA56C3F;
        for (int i = 1; i < 8; i++) pool[i] = 24'($urandom);
        @(negedge clk);
        checkResetOutputs("rst");
        releaseInit(1'b0);

        phiCycle(1'b0, 1'b1, 24'hA56C3F, 8'h5A);
        phiCycle(1'b1, 1'b0, 24'hA56C3F, 8'h00);

        refBase = refCnt; actBase = actCnt;
        repeat (100) phiCycle(1'b0, 1'b0, 24'h0, 8'h00);
        chk("idle_refs", 32'(refCnt - refBase), 32'd100);
        chk("idle_acts", 32'(actCnt - actBase), 32'd0);
        chk("idle_dout", 32'(Dout), 32'h5A);

        phiCycle(1'b1, 1'b1, 24'hA56C3F, 8'hE7);
        phiFast(pool[1], 8'h3C);
        phiCycle(1'b1, 1'b0, pool[1], 8'h00);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            a  = pool[$urandom_range(0, 7)];
            phiCycle(op[0], op[1], a, 8'($urandom));
        end

        midReset(pool[2]);
        phiCycle(1'b0, 1'b1, pool[3], 8'h96);
        phiCycle(1'b1, 1'b0, pool[3], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
